cond_unit: RTL
==============

Name: cond_unit

Overview:
- Consumer end of the ALU flag interface (Negative, Zero, Carry, Overflow) in the single-cycle ARM-style datapath.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field of the current instruction against the stored flags.
- Gates the decoder's PC, register and memory write strobes by the condition result.
- Also exposes a registered copy of the condition result and flags for the multicycle control path.

Parameters:
- FLAG_W, 4, width of the flag vector {N,Z,C,V}.
- UNDEF_NEVER, 1, when 1 cond 4'b1111 evaluates false and raises CondUndef; when 0 it behaves as AL.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- Cond  input  4  instruction condition field Instr[31:28].
- ALUFlags  input  4  {Negative, Zero, Carry, Overflow} from ALU, same order as the ALU flag outputs.
- FlagW  input  2  [1]=update N,Z; [0]=update C,V.
- PCS  input  1  decoder: instruction writes PC.
- RegW  input  1  decoder: instruction writes register file.
- MemW  input  1  decoder: instruction writes memory.
- NoWrite  input  1  decoder: compare-type op, suppress RegWrite.
- PCSrc  output  1  gated PCS.
- RegWrite  output  1  gated RegW.
- MemWrite  output  1  gated MemW.
- CondEx  output  1  combinational condition result.
- CondExReg  output  1  CondEx registered at clk.
- Flags  output  4  current stored {N,Z,C,V}.
- CondUndef  output  1  combinational, Cond==4'b1111 and UNDEF_NEVER=1.

Behaviour:
- Reset (async, active-high): Flags=4'b0000, CondExReg=0 immediately. Combinational outputs follow from the cleared flags. Reset mid-instruction discards any pending flag write.
- Condition decode (combinational, on stored Flags, not ALUFlags):
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 1; 1111 per UNDEF_NEVER.
- Gating, all combinational:
  - PCSrc=PCS&CondEx; MemWrite=MemW&CondEx; RegWrite=RegW&CondEx&!NoWrite.
- Flag update, rising clk:
  - N,Z <= ALUFlags[3:2] when FlagW[1]&CondEx.
  - C,V <= ALUFlags[1:0] when FlagW[0]&CondEx.
  - Groups update independently; an unselected group holds its value.
- Latency:
  - Flags written in cycle k are visible to CondEx in cycle k+1. There is no same-cycle bypass.
  - An instruction's condition always uses flags from before its own execution.
- Simultaneous events:
  - A failing-condition instruction with FlagW=2'b11 leaves Flags unchanged.
  - A passing instruction whose flag update would flip its own condition still writes this cycle's strobes.
- CondExReg <= CondEx every clk edge.
- CondUndef does not gate anything itself; control decides the trap.
- X on Cond with no write strobes asserted must not corrupt Flags.

Decomposition:
- Shared package holds:
  - cond code constants (COND_EQ..COND_NV, 4 bits);
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0);
  - FlagW encodings (FLAGW_NONE, FLAGW_NZ, FLAGW_CV, FLAGW_ALL).
- One natural sub-module: cond_check, a purely combinational Cond+Flags -> CondEx/CondUndef evaluator, reusable by a later pipelined version.
- The top level keeps the flag registers, CondExReg and the gating.

Test Plan:
- Reset then Cond=0000 (EQ), PCS=RegW=MemW=1 -> Flags=0000, CondEx=0, all strobes 0. Cond=1110 -> all strobes 1.
- SUB 4-5: ALUFlags=1000, FlagW=11, Cond=1110 -> after edge Flags=1000. Next cycle Cond=1011 (LT) -> CondEx=1; Cond=1010 (GE) -> 0.
- Flags=1000, ALUFlags=0110, FlagW=10, Cond=1110 -> Flags=0100 (C,V held at 0). Next cycle FlagW=01, ALUFlags=0011 -> Flags=0111.
- Flags=0100, Cond=0001 (NE, fails), FlagW=11, ALUFlags=1001 -> Flags stay 0100; RegWrite=MemWrite=PCSrc=0.
- CMP: Cond=1110, RegW=1, NoWrite=1, FlagW=11 -> RegWrite=0, flags updated. Cond=1111 with UNDEF_NEVER=1 -> CondEx=0, CondUndef=1.
- Assert reset asynchronously mid-cycle with Flags=1111 -> Flags=0000 and CondExReg=0 before the next clk edge. Hold reset across an edge with FlagW=11 -> no update.

Source files
------------

// File: rtl/cond_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : cond_unit_pkg
// Brief  : Condition codes, NZCV bit positions and FlagW encodings shared by
//          the condition unit and its evaluator.
// Rev    : 1.0  initial release
// ============================================================================
package cond_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_CV   = 2'b01;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_ALL  = 2'b11;

endpackage : cond_unit_pkg
`default_nettype wire

// File: rtl/cond_unit_check.sv
`default_nettype none
// ============================================================================
// Module : cond_check
// Brief  : Purely combinational evaluator of a 4-bit condition field against
//          a stored NZCV flag vector.
// Rev    : 1.0  initial release
// ============================================================================
module cond_check
    import cond_unit_pkg::*;
#(
    parameter int FLAG_W      = 4,
    parameter int UNDEF_NEVER = 1
) (
    input  logic [3:0]        i_cond,
    input  logic [FLAG_W-1:0] i_flags,
    output logic              o_cond_ex,
    output logic              o_cond_undef
);

    localparam logic c_undef_never = (UNDEF_NEVER != 0);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = i_flags[FLAG_N];
    assign w_z  = i_flags[FLAG_Z];
    assign w_c  = i_flags[FLAG_C];
    assign w_v  = i_flags[FLAG_V];
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = !w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = !w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = !w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = !w_v;
            COND_HI: o_cond_ex = w_c && !w_z;
            COND_LS: o_cond_ex = !w_c || w_z;
            COND_GE: o_cond_ex = w_ge;
            COND_LT: o_cond_ex = !w_ge;
            COND_GT: o_cond_ex = !w_z && w_ge;
            COND_LE: o_cond_ex = w_z || !w_ge;
            COND_AL: o_cond_ex = 1'b1;
            COND_NV: o_cond_ex = !c_undef_never;
            default: o_cond_ex = 1'b0;
        endcase
    end

    assign o_cond_undef = c_undef_never && (i_cond == COND_NV);

endmodule : cond_check
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module : cond_unit
// Brief  : NZCV flag register, condition evaluation and write-strobe gating
//          for the ARM-style datapath.
// Rev    : 1.0  initial release
// ============================================================================
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int FLAG_W      = 4,
    parameter int UNDEF_NEVER = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        Cond,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NoWrite,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              CondEx,
    output logic              CondExReg,
    output logic [FLAG_W-1:0] Flags,
    output logic              CondUndef
);

    logic [FLAG_W-1:0] r_flags;
    logic              r_cond_ex_reg;
    logic              w_cond_ex;
    logic              w_cond_undef;
    logic              w_upd_nz;
    logic              w_upd_cv;

    // Evaluated on the stored flags only, so an instruction never sees its own update.
    cond_check #(
        .FLAG_W      (FLAG_W),
        .UNDEF_NEVER (UNDEF_NEVER)
    ) u_cond_check (
        .i_cond       (Cond),
        .i_flags      (r_flags),
        .o_cond_ex    (w_cond_ex),
        .o_cond_undef (w_cond_undef)
    );

    assign w_upd_nz = FlagW[1] && w_cond_ex;
    assign w_upd_cv = FlagW[0] && w_cond_ex;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags       <= '0;
            r_cond_ex_reg <= 1'b0;
        end else begin
            if (w_upd_nz) begin
                r_flags[FLAG_N] <= ALUFlags[FLAG_N];
                r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (w_upd_cv) begin
                r_flags[FLAG_C] <= ALUFlags[FLAG_C];
                r_flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
            r_cond_ex_reg <= w_cond_ex;
        end
    end

    assign PCSrc     = PCS  && w_cond_ex;
    assign MemWrite  = MemW && w_cond_ex;
    assign RegWrite  = RegW && w_cond_ex && !NoWrite;
    assign CondEx    = w_cond_ex;
    assign CondExReg = r_cond_ex_reg;
    assign Flags     = r_flags;
    assign CondUndef = w_cond_undef;

endmodule : cond_unit
`default_nettype wire
